// File: rtl/linear_layer_i4xi4_q_start_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | linear_layer_i4xi4_q_start_fifo_pkg                                      |
// | Handshake operation decode shared by the start-token FIFO.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package linear_layer_i4xi4_q_start_fifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_BOTH = 2'd3
    } fifo_op_e;

    function automatic fifo_op_e decode_op(input logic push, input logic pop);
        return fifo_op_e'({pop, push});
    endfunction

endpackage
`default_nettype wire

// File: rtl/linear_layer_i4xi4_q_start_fifo_srl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | linear_layer_i4xi4_q_start_fifo_srl                                      |
// | Shift-register token storage with a random-access read tap.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module linear_layer_i4xi4_q_start_fifo_srl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    // Addresses beyond DEPTH-1 only occur while empty, where dout is don't-care.
    always_comb begin
        dout = r_mem[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_WIDTH'(i)) begin
                dout = r_mem[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/linear_layer_i4xi4_q_start_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | linear_layer_i4xi4_q_start_fifo                                          |
// | Shift-register FIFO with registered empty/full flags and enables.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module linear_layer_i4xi4_q_start_fifo
    import linear_layer_i4xi4_q_start_fifo_pkg::*;
#(
    parameter     MEM_STYLE  = "shiftreg",
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic                  if_empty_n,
    output logic [DATA_WIDTH-1:0] if_dout,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n
);

    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_cnt_w-1:0]    w_cnt_next;
    logic                  r_empty_n;
    logic                  r_full_n;
    logic                  w_push;
    logic                  w_pop;
    fifo_op_e              w_op;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_push = if_write & if_write_ce & r_full_n;
    assign w_pop  = if_read  & if_read_ce  & r_empty_n;
    assign w_op   = decode_op(w_push, w_pop);

    always_comb begin
        w_cnt_next = r_cnt;
        case (w_op)
            OP_PUSH: w_cnt_next = r_cnt + c_cnt_w'(1);
            OP_POP:  w_cnt_next = r_cnt - c_cnt_w'(1);
            default: w_cnt_next = r_cnt;
        endcase
    end

    // Flags are registered from the next count so they line up with r_cnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_empty_n <= 1'b0;
            r_full_n  <= 1'b1;
        end else begin
            r_cnt     <= w_cnt_next;
            r_empty_n <= (w_cnt_next != '0);
            r_full_n  <= (w_cnt_next != c_cnt_w'(DEPTH));
        end
    end

    // The oldest token sits at slot cnt-1 because every push shifts up by one.
    assign w_addr = ADDR_WIDTH'(r_cnt - c_cnt_w'(1));

    linear_layer_i4xi4_q_start_fifo_srl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_srl (
        .clk  (clk),
        .we   (w_push),
        .addr (w_addr),
        .din  (if_din),
        .dout (if_dout)
    );

    assign if_empty_n = r_empty_n;
    assign if_full_n  = r_full_n;

endmodule
`default_nettype wire

// File: tb/tb_linear_layer_i4xi4_q_start_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_linear_layer_i4xi4_q_start_fifo                                       |
// | Scoreboard bench: queue-based token model against the FIFO.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_linear_layer_i4xi4_q_start_fifo;

    localparam int DW    = 8;
    localparam int AW    = 1;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic          chk;
        logic          empty_n;
        logic          full_n;
        logic [DW-1:0] head;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_read_ce = 1'b0;
    logic          if_read = 1'b0;
    logic          if_empty_n;
    logic [DW-1:0] if_dout;
    logic          if_write_ce = 1'b0;
    logic          if_write = 1'b0;
    logic [DW-1:0] if_din = '0;
    logic          if_full_n;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_q [$];
    exp_t          flag_q [$];
    logic          model_known = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    linear_layer_i4xi4_q_start_fifo #(
        .MEM_STYLE  ("shiftreg"),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_read_ce  (if_read_ce),
        .if_read     (if_read),
        .if_empty_n  (if_empty_n),
        .if_dout     (if_dout),
        .if_write_ce (if_write_ce),
        .if_write    (if_write),
        .if_din      (if_din),
        .if_full_n   (if_full_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model records what the FIFO must show this cycle.
    task automatic drive(input logic w, input logic wce, input logic [DW-1:0] d,
                         input logic r, input logic rce, input logic rst);
        exp_t e;
        logic do_push;
        logic do_pop;
        @(posedge clk);
        #1;
        if_write    = w;
        if_write_ce = wce;
        if_din      = d;
        if_read     = r;
        if_read_ce  = rce;
        reset       = rst;
        e.chk     = model_known;
        e.empty_n = (model_q.size() != 0);
        e.full_n  = (model_q.size() != DEPTH);
        e.head    = (model_q.size() != 0) ? model_q[0] : '0;
        flag_q.push_back(e);
        if (rst) begin
            model_q.delete();
            model_known = 1'b1;
        end else if (model_known) begin
            do_pop  = r && rce && (model_q.size() != 0);
            do_push = w && wce && (model_q.size() != DEPTH);
            if (do_pop) exp_q.push_back(model_q.pop_front());
            if (do_push) model_q.push_back(d);
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [DW-1:0] d);
        drive(1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    endtask

    // Monitor: checks flags/head each cycle and dequeues expected data on every pop.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (flag_q.size() != 0) begin
                e = flag_q.pop_front();
                if (e.chk) begin
                    check("empty_n", 32'(if_empty_n), 32'(e.empty_n));
                    check("full_n", 32'(if_full_n), 32'(e.full_n));
                    if (e.empty_n) check("dout_head", 32'(if_dout), 32'(e.head));
                end
            end
            if (!reset && if_read && if_read_ce && if_empty_n) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 32'(1), 32'(0));
                end else begin
                    check("pop_data", 32'(if_dout), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle();
        // Single token visible one cycle after push.
        push(8'h01);
        pop();
        idle();
        // Fill to full, third push ignored, pops in order.
        push(8'h00);
        push(8'h01);
        push(8'h5a);
        pop();
        pop();
        idle();
        // Simultaneous push and pop at one held token.
        push(8'h0a);
        drive(1'b1, 1'b1, 8'h0b, 1'b1, 1'b1, 1'b0);
        idle();
        pop();
        idle();
        // Full with read and write: only the pop happens.
        push(8'h11);
        push(8'h22);
        drive(1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
        idle();
        pop();
        idle();
        // Gated enables.
        repeat (3) drive(1'b1, 1'b0, 8'hee, 1'b1, 1'b0, 1'b0);
        idle();
        // Mid-operation reset then immediate push.
        push(8'h44);
        push(8'h55);
        drive(1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 1'b1);
        push(8'h77);
        idle();
        pop();
        idle();
        // Randomized traffic with phases biased toward filling or draining.
        for (int i = 0; i < 3000; i++) begin
            logic wbias;
            wbias = i[6];
            drive(wbias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 7) != 0,
                  DW'($urandom),
                  wbias ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 7) != 0,
                  $urandom_range(0, 199) == 0);
        end
        idle();
        idle();
        @(negedge clk);
        #1;
        check("drain_exp_q", 32'(exp_q.size()), 32'(0));
        check("drain_flag_q", 32'(flag_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/linear_layer_i4xi4_q_start_fifo.md
LINEAR_LAYER_I4XI4_Q_START_FIFO -- requirements
Module: linear_layer_i4xi4_q_start_fifo

Interface
REQ-001 SHALL have parameter MEM_STYLE, default "shiftreg": storage style tag, informational only.
REQ-002 SHALL have parameter DATA_WIDTH, default 1: token width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 1: read-address width, with 2**ADDR_WIDTH >= DEPTH.
REQ-004 SHALL have parameter DEPTH, default 2: number of token slots, DEPTH >= 1.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port if_read_ce, input, 1: read-side clock enable.
REQ-008 SHALL have port if_read, input, 1: consumer pops the head token.
REQ-009 SHALL have port if_empty_n, output, 1: high when at least one token is held.
REQ-010 SHALL have port if_dout, output, DATA_WIDTH: oldest held token.
REQ-011 SHALL have port if_write_ce, input, 1: write-side clock enable.
REQ-012 SHALL have port if_write, input, 1: producer pushes if_din.
REQ-013 SHALL have port if_din, input, DATA_WIDTH: token to push.
REQ-014 SHALL have port if_full_n, output, 1: high when a free slot exists.

Function
REQ-015 SHALL define push = if_write & if_write_ce & if_full_n, and pop = if_read & if_read_ce & if_empty_n.
REQ-016 SHALL keep an occupancy count cnt in the range 0..DEPTH: push only -> cnt+1; pop only -> cnt-1; both or neither -> unchanged.
REQ-017 SHALL register if_empty_n and if_full_n: next if_empty_n = (next cnt != 0); next if_full_n = (next cnt != DEPTH).
REQ-018 SHALL shift if_din into slot 0 of the storage on every push, moving older tokens up one slot.
REQ-019 SHALL read if_dout combinationally from storage slot cnt-1, so it always shows the oldest token.
REQ-020 SHALL make a pushed token visible one cycle after the push: if_empty_n and if_dout are updated on the next edge.
REQ-021 SHALL, on simultaneous push and pop with 0 < cnt < DEPTH, shift the storage, keep cnt unchanged, and present the next-oldest token on if_dout.
REQ-022 SHALL, when empty, ignore if_read; if_read and if_write together while empty perform the push only.
REQ-023 SHALL, when full, ignore if_write even if a pop occurs in the same cycle; the producer retries the next cycle.
REQ-024 SHALL, when an enable (if_read_ce or if_write_ce) is low, treat that side as idle regardless of if_read or if_write.
REQ-025 SHALL leave if_dout undefined while if_empty_n is low; the consumer does not sample it then.

Reset
REQ-026 SHALL, when reset is high at a clock edge, set cnt=0, if_empty_n=0 and if_full_n=1, overriding any push or pop in that cycle.
REQ-027 SHALL NOT clear storage contents on reset.
REQ-028 SHALL, when reset is asserted mid-operation, discard all held tokens and accept a push on the first edge after reset deasserts.

Structure
REQ-029 SHALL keep all configuration as module parameters; no shared package or typedefs are required.
REQ-030 SHALL implement storage in one sub-module, linear_layer_i4xi4_q_start_fifo_srl, with ports clk, we, addr, din and dout, where we = push and addr = cnt-1 truncated to ADDR_WIDTH.
REQ-031 SHALL keep all pointer, flag and handshake logic in the top module.

Verification
REQ-032 SHALL verify single token: reset, push 1'b1 at cycle 0 -> if_empty_n=1 and if_dout=1 at cycle 1; pop at cycle 1 -> if_empty_n=0 at cycle 2.
REQ-033 SHALL verify fill to full: DEPTH=2, push A=0 then B=1 -> if_full_n=0 after the second push; a third push is ignored; pops return A then B.
REQ-034 SHALL verify simultaneous push and pop at cnt=1 holding A, pushing B -> cnt stays 1, if_full_n stays 1, if_dout=B next cycle.
REQ-035 SHALL verify full plus read and write: cnt=2 with both asserted -> only the pop occurs, cnt=1, if_full_n=1 next cycle.
REQ-036 SHALL verify gated enables: if_write=1 with if_write_ce=0 for 3 cycles -> cnt stays 0 and if_empty_n stays 0.
REQ-037 SHALL verify mid-operation reset: cnt=2 and reset pulsed for 1 cycle -> if_empty_n=0 and if_full_n=1, then a push is accepted on the next cycle.
